// File: rtl/adc_serial_rx.sv
// adc_serial_rx: reads 8-bit MSB-first conversions from a serial ADC
// (CS_n / SCLK / DOUT). It generates chip select and serial clock from clk
// and holds the last completed sample for the downstream averaging filter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CS_n high, SCLK low, waiting for en
// SETUP | CS_n low, SCLK low for DIV cycles so the ADC can drive its MSB
// SHIFT | SCLK toggles every DIV cycles; capture on each rising drive
// GAP   | CS_n high for IDLE_CYC cycles, then restart or return to IDLE

module adc_serial_rx #(
    parameter int DIV      = 4,
    parameter int IDLE_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       busy
);

    // One down-counter times both SCLK half-periods and the CS_n gap.
    localparam int CNT_MAX = (DIV > IDLE_CYC) ? DIV : IDLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          cs_n_nxt;
    logic          sclk_nxt;
    logic [7:0]    sample_nxt;
    logic          valid_nxt;
    logic          tc;
    logic          last_bit;

    assign tc       = (cnt == '0);
    assign last_bit = (bit_cnt == 3'd7);
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; completion is the falling SCLK edge after bit 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (en) state_nxt = SETUP;
            SETUP: if (tc) state_nxt = SHIFT;
            SHIFT: if (tc && adc_sclk && last_bit) state_nxt = GAP;
            GAP:   if (tc) state_nxt = en ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the timer, shifter and registered ADC/sample outputs.
    always_comb begin
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        cs_n_nxt    = adc_cs_n;
        sclk_nxt    = adc_sclk;
        sample_nxt  = sample;
        valid_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cs_n_nxt = 1'b1;
                sclk_nxt = 1'b0;
                if (en) begin
                    cs_n_nxt    = 1'b0;
                    cnt_nxt     = HALF_LOAD;
                    bit_cnt_nxt = 3'd0;
                    shift_nxt   = 8'h00;
                end
            end
            SETUP: begin
                if (tc) begin
                    sclk_nxt  = 1'b1;
                    shift_nxt = {shift[6:0], adc_dout};
                    cnt_nxt   = HALF_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SHIFT: begin
                if (tc) begin
                    cnt_nxt = HALF_LOAD;
                    if (adc_sclk) begin
                        sclk_nxt = 1'b0;
                        if (last_bit) begin
                            cs_n_nxt   = 1'b1;
                            sample_nxt = shift;
                            valid_nxt  = 1'b1;
                            cnt_nxt    = GAP_LOAD;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end else begin
                        sclk_nxt  = 1'b1;
                        shift_nxt = {shift[6:0], adc_dout};
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (tc) begin
                    if (en) begin
                        cs_n_nxt    = 1'b0;
                        cnt_nxt     = HALF_LOAD;
                        bit_cnt_nxt = 3'd0;
                        shift_nxt   = 8'h00;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset discards any partial conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            sample       <= 8'h00;
            sample_valid <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            adc_cs_n     <= cs_n_nxt;
            adc_sclk     <= sclk_nxt;
            sample       <= sample_nxt;
            sample_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// tb_adc_serial_rx: behavioural serial ADC models feed two receivers
// (DIV=4/IDLE_CYC=8 and DIV=2/IDLE_CYC=1). Words handed to the ADC model are
// queued as expected samples and compared when sample_valid pulses.

module tb_adc_serial_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a;
    logic       en_b;
    logic       a_dout;
    logic       b_dout;
    logic       a_cs_n, a_sclk, a_valid, a_busy;
    logic       b_cs_n, b_sclk, b_valid, b_busy;
    logic [7:0] a_sample, b_sample;

    int total = 0;
    int bad   = 0;

    logic [7:0] adc_qa[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] a_word = 8'h00;
    logic [7:0] b_word = 8'h00;
    int         a_bit  = 0;
    int         b_bit  = 0;

    int w_cs_low;
    int w_rises;
    int w_idle_k;
    int w_phases;
    int w_phase_bad;
    int w_valid_k[$];

    always #5 clk = ~clk;

    adc_serial_rx #(.DIV(4), .IDLE_CYC(8)) u_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en_a),
        .adc_dout     (a_dout),
        .adc_cs_n     (a_cs_n),
        .adc_sclk     (a_sclk),
        .sample       (a_sample),
        .sample_valid (a_valid),
        .busy         (a_busy)
    );

    adc_serial_rx #(.DIV(2), .IDLE_CYC(1)) u_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en_b),
        .adc_dout     (b_dout),
        .adc_cs_n     (b_cs_n),
        .adc_sclk     (b_sclk),
        .sample       (b_sample),
        .sample_valid (b_valid),
        .busy         (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC A: loads the next queued word on CS_n fall, MSB first, next bit after each SCLK fall.
    initial forever begin
        @(negedge a_cs_n);
        if (adc_qa.size() != 0) a_word = adc_qa.pop_front();
        else a_word = 8'h00;
        exp_a.push_back(a_word);
        a_bit  = 7;
        a_dout = a_word[7];
    end

    initial forever begin
        @(negedge a_sclk);
        if (a_bit > 0) begin
            a_bit  = a_bit - 1;
            a_dout = a_word[a_bit];
        end
    end

    // ADC B: always converts 0xC3.
    initial forever begin
        @(negedge b_cs_n);
        b_word = 8'hC3;
        exp_b.push_back(b_word);
        b_bit  = 7;
        b_dout = b_word[7];
    end

    initial forever begin
        @(negedge b_sclk);
        if (b_bit > 0) begin
            b_bit  = b_bit - 1;
            b_dout = b_word[b_bit];
        end
    end

    // Scoreboard: each sample_valid pops the oldest expected word.
    initial forever begin
        @(negedge clk);
        if (a_valid === 1'b1) begin
            check("a_exp_avail", (exp_a.size() != 0), 1);
            if (exp_a.size() != 0) check("a_sample", a_sample, exp_a.pop_front());
        end
        if (b_valid === 1'b1) begin
            check("b_exp_avail", (exp_b.size() != 0), 1);
            if (exp_b.size() != 0) check("b_sample", b_sample, exp_b.pop_front());
        end
    end

    // Observe one receiver for n cycles, sampling 1 time unit after each edge;
    // k=0 is the sample taken just after the call.
    task automatic watch(input bit b, input int n);
        logic cs, s, v, bz, prev_s;
        int   run;
        int   div;
        bit   started;
        bit   run_cs_ok;
        div         = b ? 2 : 4;
        w_cs_low    = 0;
        w_rises     = 0;
        w_idle_k    = -1;
        w_phases    = 0;
        w_phase_bad = 0;
        w_valid_k.delete();
        prev_s    = b ? b_sclk : a_sclk;
        run       = 0;
        started   = 1'b0;
        run_cs_ok = 1'b1;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            cs = b ? b_cs_n  : a_cs_n;
            s  = b ? b_sclk  : a_sclk;
            v  = b ? b_valid : a_valid;
            bz = b ? b_busy  : a_busy;
            if (!cs) w_cs_low++;
            if (v) w_valid_k.push_back(k);
            if (!bz && (w_idle_k < 0) && (k > 0)) w_idle_k = k;
            if ((k > 0) && (s != prev_s)) begin
                if (s) w_rises++;
                if (started && (prev_s || run_cs_ok)) begin
                    w_phases++;
                    if (run != div) w_phase_bad++;
                end
                started   = 1'b1;
                run       = 0;
                run_cs_ok = 1'b1;
            end
            run++;
            if (cs) run_cs_ok = 1'b0;
            prev_s = s;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        a_dout = 1'b0;
        b_dout = 1'b0;
        #22;
        check("rst0_cs_n",  a_cs_n,   1);
        check("rst0_sclk",  a_sclk,   0);
        check("rst0_sample", a_sample, 8'h00);
        check("rst0_valid", a_valid,  0);
        check("rst0_busy",  a_busy,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single conversion, one-cycle en pulse
        adc_qa.push_back(8'hA5);
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk);
        #1;
        en_a = 1'b0;
        watch(0, 90);
        check("t2_cs_low",  w_cs_low, 64);
        check("t2_rises",   w_rises,  8);
        check("t2_nvalid",  w_valid_k.size(), 1);
        if (w_valid_k.size() > 0) check("t2_valid_k", w_valid_k[0], 64);
        check("t2_idle_k",  w_idle_k, 72);
        check("t2_phases",  w_phases, 15);
        check("t2_phase_bad", w_phase_bad, 0);
        check("t2_held",    a_sample, 8'hA5);

        // continuous enable, three words
        adc_qa.push_back(8'h00);
        adc_qa.push_back(8'hFF);
        adc_qa.push_back(8'h3C);
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk);
        #1;
        fork
            watch(0, 230);
            begin
                repeat (180) @(posedge clk);
                #2;
                en_a = 1'b0;
            end
        join
        check("t3_nvalid", w_valid_k.size(), 3);
        if (w_valid_k.size() == 3) begin
            check("t3_valid_k0", w_valid_k[0], 64);
            check("t3_gap1", w_valid_k[1] - w_valid_k[0], 72);
            check("t3_gap2", w_valid_k[2] - w_valid_k[1], 72);
        end
        check("t3_idle_k", w_idle_k, 216);
        check("t3_exp_left", exp_a.size(), 0);
        check("t3_held", a_sample, 8'h3C);

        // en dropped at bit 3: conversion still completes
        adc_qa.push_back(8'h5A);
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk);
        #1;
        fork
            watch(0, 100);
            begin
                repeat (36) @(posedge clk);
                #2;
                en_a = 1'b0;
            end
        join
        check("t4_nvalid", w_valid_k.size(), 1);
        if (w_valid_k.size() > 0) check("t4_valid_k", w_valid_k[0], 64);
        check("t4_idle_k", w_idle_k, 72);
        check("t4_cs_low", w_cs_low, 64);
        check("t4_held",   a_sample, 8'h5A);

        // asynchronous reset mid-SHIFT after 4 bits, restart with en held
        adc_qa.push_back(8'h7E);
        adc_qa.push_back(8'h81);
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_cs_n",   a_cs_n,   1);
        check("t5_rst_sclk",   a_sclk,   0);
        check("t5_rst_sample", a_sample, 8'h00);
        check("t5_rst_valid",  a_valid,  0);
        check("t5_rst_busy",   a_busy,   0);
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            watch(0, 90);
            begin
                repeat (10) @(posedge clk);
                #2;
                en_a = 1'b0;
            end
        join
        check("t5_nvalid", w_valid_k.size(), 1);
        if (w_valid_k.size() > 0) check("t5_valid_k", w_valid_k[0], 64);
        check("t5_idle_k", w_idle_k, 72);
        check("t5_exp_left", exp_a.size(), 0);
        check("t5_held", a_sample, 8'h81);

        // DIV=2, IDLE_CYC=1 continuous
        @(negedge clk);
        en_b = 1'b1;
        @(posedge clk);
        #1;
        fork
            watch(1, 110);
            begin
                repeat (70) @(posedge clk);
                #2;
                en_b = 1'b0;
            end
        join
        check("t6_nvalid", w_valid_k.size(), 3);
        if (w_valid_k.size() == 3) begin
            check("t6_valid_k0", w_valid_k[0], 32);
            check("t6_gap1", w_valid_k[1] - w_valid_k[0], 33);
            check("t6_gap2", w_valid_k[2] - w_valid_k[1], 33);
        end
        check("t6_phases",    w_phases, 45);
        check("t6_phase_bad", w_phase_bad, 0);
        check("t6_rises",     w_rises, 24);
        check("t6_idle_k",    w_idle_k, 99);
        check("t6_exp_left",  exp_b.size(), 0);
        check("t6_held",      b_sample, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
